// File: rtl/cmp_set_seq_if.sv
// Request/response bundle for the sliced set-on-condition compare unit.
interface cmp_set_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, op, a, b,
    input  busy, done, result, lt, eq, gt
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, lt, eq, gt
  );
endinterface

// File: rtl/cmp_set_seq.sv
// Multi-cycle set-on-condition unit: compares A and B one CHUNK-bit slice per
// cycle from the top slice down, returning {0.., flag} plus raw lt/eq/gt.
// Signed ordering comes from flipping the sign bit of the top slice only, so
// the compare is exact and never suffers subtraction overflow.
module cmp_set_seq #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHUNK      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  cmp_set_seq_if.slave bus
);

  localparam int unsigned STEPS = WIDTH / CHUNK;
  localparam int unsigned IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(STEPS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_SLT  = 3'b000;
  localparam logic [2:0] OP_SLTU = 3'b001;
  localparam logic [2:0] OP_SGT  = 3'b010;
  localparam logic [2:0] OP_SGTU = 3'b011;
  localparam logic [2:0] OP_SEQ  = 3'b100;
  localparam logic [2:0] OP_SNE  = 3'b101;
  localparam logic [2:0] OP_SLE  = 3'b110;
  localparam logic [2:0] OP_SGE  = 3'b111;

  logic [1:0]       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_decided, w_decided_nxt;
  logic             r_dlt, w_dlt_nxt;
  logic             r_dgt, w_dgt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_flag, w_flag_nxt;
  logic             r_lt, w_lt_nxt;
  logic             r_eq, w_eq_nxt;
  logic             r_gt, w_gt_nxt;

  logic [CHUNK-1:0] w_sa, w_sb;
  logic [CHUNK-1:0] w_flip;
  logic [CHUNK-1:0] w_ca, w_cb;
  logic             w_signed;
  logic             w_slc_lt, w_slc_gt, w_diff;
  logic             w_fin_lt, w_fin_gt, w_fin_eq;
  logic             w_fin_flag;
  logic             w_last;

  // Select the slice currently addressed by the scan index.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sa = r_a[i*CHUNK +: CHUNK];
        w_sb = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  // Slice compare; the top slice of a signed op gets its sign bit inverted.
  always_comb begin
    w_signed   = (r_op == OP_SLT) || (r_op == OP_SGT) ||
                 (r_op == OP_SLE) || (r_op == OP_SGE);
    w_flip     = CHUNK'((w_signed && (r_idx == IDX_TOP)) ? 1 : 0) << (CHUNK - 1);
    w_ca       = w_sa ^ w_flip;
    w_cb       = w_sb ^ w_flip;
    w_slc_lt   = (w_ca < w_cb);
    w_slc_gt   = (w_ca > w_cb);
    w_diff     = (w_ca != w_cb);
    w_fin_lt   = r_decided ? r_dlt : w_slc_lt;
    w_fin_gt   = r_decided ? r_dgt : w_slc_gt;
    w_fin_eq   = !(r_decided || w_diff);
    w_last     = (EARLY_EXIT && w_diff) || (r_idx == '0);
    w_fin_flag = 1'b0;
    case (r_op)
      OP_SLT, OP_SLTU: w_fin_flag = w_fin_lt;
      OP_SGT, OP_SGTU: w_fin_flag = w_fin_gt;
      OP_SEQ:          w_fin_flag = w_fin_eq;
      OP_SNE:          w_fin_flag = !w_fin_eq;
      OP_SLE:          w_fin_flag = w_fin_lt || w_fin_eq;
      OP_SGE:          w_fin_flag = w_fin_gt || w_fin_eq;
      default:         w_fin_flag = 1'b0;
    endcase
  end

  // Next-state and next-output logic; IDLE and DONE both accept a new request.
  always_comb begin
    w_state_nxt   = r_state;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_op_nxt      = r_op;
    w_idx_nxt     = r_idx;
    w_decided_nxt = r_decided;
    w_dlt_nxt     = r_dlt;
    w_dgt_nxt     = r_dgt;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_flag_nxt    = r_flag;
    w_lt_nxt      = r_lt;
    w_eq_nxt      = r_eq;
    w_gt_nxt      = r_gt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_a_nxt       = bus.a;
          w_b_nxt       = bus.b;
          w_op_nxt      = bus.op;
          w_idx_nxt     = IDX_TOP;
          w_decided_nxt = 1'b0;
          w_dlt_nxt     = 1'b0;
          w_dgt_nxt     = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_SCAN;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_SCAN: begin
        w_busy_nxt = 1'b1;
        if (w_diff && !r_decided) begin
          w_decided_nxt = 1'b1;
          w_dlt_nxt     = w_slc_lt;
          w_dgt_nxt     = w_slc_gt;
        end
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_flag_nxt  = w_fin_flag;
          w_lt_nxt    = w_fin_lt;
          w_eq_nxt    = w_fin_eq;
          w_gt_nxt    = w_fin_gt;
        end else begin
          w_idx_nxt   = r_idx - IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_idx     <= '0;
      r_decided <= 1'b0;
      r_dlt     <= 1'b0;
      r_dgt     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_flag    <= 1'b0;
      r_lt      <= 1'b0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_op      <= w_op_nxt;
      r_idx     <= w_idx_nxt;
      r_decided <= w_decided_nxt;
      r_dlt     <= w_dlt_nxt;
      r_dgt     <= w_dgt_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_flag    <= w_flag_nxt;
      r_lt      <= w_lt_nxt;
      r_eq      <= w_eq_nxt;
      r_gt      <= w_gt_nxt;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = {{(WIDTH-1){1'b0}}, r_flag};
  assign bus.lt     = r_lt;
  assign bus.eq     = r_eq;
  assign bus.gt     = r_gt;

endmodule

// File: tb/tb_cmp_set_seq.sv
// Scoreboard bench for cmp_set_seq: one early-exit instance and one
// full-scan instance, directed vectors with hand-computed expectations.
module tb_cmp_set_seq;

  localparam int unsigned WIDTH = 32;

  localparam logic [2:0] SLT  = 3'b000;
  localparam logic [2:0] SLTU = 3'b001;
  localparam logic [2:0] SGT  = 3'b010;
  localparam logic [2:0] SGTU = 3'b011;
  localparam logic [2:0] SEQ  = 3'b100;
  localparam logic [2:0] SNE  = 3'b101;
  localparam logic [2:0] SLE  = 3'b110;
  localparam logic [2:0] SGE  = 3'b111;

  typedef struct {
    logic        flag;
    logic        lt;
    logic        eq;
    logic        gt;
    int unsigned done_edge;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;

  cmp_set_seq_if #(.WIDTH(WIDTH)) bus_ee ();
  cmp_set_seq_if #(.WIDTH(WIDTH)) bus_fs ();

  cmp_set_seq #(.WIDTH(WIDTH), .CHUNK(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_ee)
  );

  cmp_set_seq #(.WIDTH(WIDTH), .CHUNK(8), .EARLY_EXIT(1'b0)) dut_fs (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_fs)
  );

  exp_t        q_ee[$];
  exp_t        q_fs[$];
  exp_t        e_ee;
  exp_t        e_fs;
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned edge_cnt = 0;
  logic        prev_done_ee = 1'b0;
  logic        prev_done_fs = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, want);
    end
  endtask

  task automatic sb_compare(input exp_t e, input logic [31:0] res, input logic lt,
                            input logic eq, input logic gt);
    check({e.name, " result"}, res, {31'b0, e.flag});
    check({e.name, " lt"}, 32'(lt), 32'(e.lt));
    check({e.name, " eq"}, 32'(eq), 32'(e.eq));
    check({e.name, " gt"}, 32'(gt), 32'(e.gt));
    check({e.name, " done_edge"}, edge_cnt, e.done_edge);
  endtask

  // Early-exit monitor: every done pops and checks one expectation.
  always begin
    @(posedge clk);
    #1;
    if (bus_ee.done === 1'b1) begin
      check("ee done_width", 32'(prev_done_ee), 32'd0);
      check("ee sb_nonempty", 32'(q_ee.size() != 0), 32'd1);
      if (q_ee.size() != 0) begin
        e_ee = q_ee.pop_front();
        sb_compare(e_ee, bus_ee.result, bus_ee.lt, bus_ee.eq, bus_ee.gt);
      end
    end
    prev_done_ee = bus_ee.done;
  end

  // Full-scan monitor.
  always begin
    @(posedge clk);
    #1;
    if (bus_fs.done === 1'b1) begin
      check("fs done_width", 32'(prev_done_fs), 32'd0);
      check("fs sb_nonempty", 32'(q_fs.size() != 0), 32'd1);
      if (q_fs.size() != 0) begin
        e_fs = q_fs.pop_front();
        sb_compare(e_fs, bus_fs.result, bus_fs.lt, bus_fs.eq, bus_fs.gt);
      end
    end
    prev_done_fs = bus_fs.done;
  end

  // Drive one request (called #1 after an edge); returns #1 after the accepting edge.
  task automatic issue(input bit fs, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic flag, input logic lt,
                       input logic eq, input logic gt, input int unsigned lat,
                       input string name, input bit push);
    exp_t e;
    e.flag      = flag;
    e.lt        = lt;
    e.eq        = eq;
    e.gt        = gt;
    e.done_edge = edge_cnt + lat;
    e.name      = name;
    if (fs) begin
      bus_fs.op = op; bus_fs.a = a; bus_fs.b = b; bus_fs.start = 1'b1;
      if (push) q_fs.push_back(e);
    end else begin
      bus_ee.op = op; bus_ee.a = a; bus_ee.b = b; bus_ee.start = 1'b1;
      if (push) q_ee.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fs) begin
      bus_fs.start = 1'b0; bus_fs.op = 3'($urandom); bus_fs.a = $urandom; bus_fs.b = $urandom;
    end else begin
      bus_ee.start = 1'b0; bus_ee.op = 3'($urandom); bus_ee.a = $urandom; bus_ee.b = $urandom;
    end
  endtask

  task automatic wait_done(input bit fs);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = fs ? bus_fs.done : bus_ee.done;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_done timeout: got no done, want done within 40 cycles (fs=%0d)", fs);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    bus_ee.start = 1'b0; bus_ee.op = '0; bus_ee.a = '0; bus_ee.b = '0;
    bus_fs.start = 1'b0; bus_fs.op = '0; bus_fs.a = '0; bus_fs.b = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset busy",   32'(bus_ee.busy), 32'd0);
    check("reset done",   32'(bus_ee.done), 32'd0);
    check("reset result", bus_ee.result, 32'd0);
    check("reset lt",     32'(bus_ee.lt), 32'd0);
    check("reset eq",     32'(bus_ee.eq), 32'd0);
    check("reset gt",     32'(bus_ee.gt), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycle();

    // Early-exit directed vectors: op, a, b, flag, lt, eq, gt, latency.
    issue(0, SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 0, 0, 2, "slt_neg1_1", 1);  wait_done(0); idle_cycle();
    issue(0, SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 1, 2, "sltu_ff_1", 1);   wait_done(0); idle_cycle();
    issue(0, SGT,  32'h7FFF_FFFF, 32'h8000_0000, 1, 0, 0, 1, 2, "sgt_ovf", 1);     wait_done(0); idle_cycle();
    issue(0, SLT,  32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 0, 1, 2, "slt_ovf", 1);     wait_done(0); idle_cycle();
    issue(0, SEQ,  32'h1234_5678, 32'h1234_5678, 1, 0, 1, 0, 5, "seq_eq", 1);      wait_done(0); idle_cycle();
    issue(0, SLTU, 32'h1234_5600, 32'h1234_5601, 1, 1, 0, 0, 5, "sltu_low", 1);    wait_done(0); idle_cycle();
    issue(0, SLE,  32'hCAFE_BABE, 32'hCAFE_BABE, 1, 0, 1, 0, 5, "sle_eq", 1);      wait_done(0); idle_cycle();
    issue(0, SNE,  32'hCAFE_BABE, 32'hCAFE_BABE, 0, 0, 1, 0, 5, "sne_eq", 1);      wait_done(0); idle_cycle();
    issue(0, SGTU, 32'h0001_0000, 32'h0000_FFFF, 1, 0, 0, 1, 3, "sgtu_j1", 1);     wait_done(0); idle_cycle();
    issue(0, SGE,  32'h8000_0000, 32'h0000_0001, 0, 1, 0, 0, 2, "sge_min", 1);     wait_done(0); idle_cycle();
    issue(0, SLE,  32'hFFFF_FF00, 32'hFFFF_FF01, 1, 1, 0, 0, 5, "sle_neg", 1);     wait_done(0); idle_cycle();
    issue(0, SNE,  32'h0000_0100, 32'h0000_0000, 1, 0, 0, 1, 4, "sne_j2", 1);      wait_done(0); idle_cycle();

    // start during busy is ignored; only the original result comes back.
    issue(0, SEQ, 32'h0000_0000, 32'h0000_0000, 1, 0, 1, 0, 5, "busy_ignore", 1);
    bus_ee.op = SNE; bus_ee.a = 32'h1; bus_ee.b = 32'h2; bus_ee.start = 1'b1;
    idle_cycle();
    bus_ee.start = 1'b0;
    wait_done(0);
    idle_cycle();
    check("busy_ignore busy_after", 32'(bus_ee.busy), 32'd0);
    check("busy_ignore queue_empty", 32'(q_ee.size()), 32'd0);

    // start held in the DONE cycle is accepted immediately.
    issue(0, SGT, 32'h0000_0005, 32'h0000_0003, 1, 0, 0, 1, 5, "b2b_first", 1);
    wait_done(0);
    issue(0, SLTU, 32'h0000_0001, 32'h0000_0002, 1, 1, 0, 0, 5, "b2b_second", 1);
    check("b2b busy_next", 32'(bus_ee.busy), 32'd1);
    check("b2b done_low", 32'(bus_ee.done), 32'd0);
    wait_done(0);
    idle_cycle();

    // Reset in the second SCAN cycle aborts at once.
    issue(0, SLTU, 32'h0000_1234, 32'h0000_1234, 0, 0, 1, 0, 5, "aborted", 0);
    idle_cycle();
    check("abort busy_pre", 32'(bus_ee.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy",   32'(bus_ee.busy), 32'd0);
    check("abort done",   32'(bus_ee.done), 32'd0);
    check("abort result", bus_ee.result, 32'd0);
    check("abort eq",     32'(bus_ee.eq), 32'd0);
    idle_cycle();
    rst_n = 1'b1;
    idle_cycle();
    issue(0, SGE, 32'd5, 32'd5, 1, 0, 1, 0, 5, "sge_after_rst", 1);
    wait_done(0);
    idle_cycle();

    // Full-scan instance: latency is always STEPS+1 and lt survives equal low slices.
    issue(1, SLTU, 32'h0000_0000, 32'hFF00_0000, 1, 1, 0, 0, 5, "fs_sltu_top", 1); wait_done(1); idle_cycle();
    issue(1, SGE,  32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 1, 0, 0, 5, "fs_sge_neg", 1);  wait_done(1); idle_cycle();
    issue(1, SEQ,  32'h0000_00AB, 32'h0000_00AB, 1, 0, 1, 0, 5, "fs_seq", 1);      wait_done(1); idle_cycle();

    repeat (3) idle_cycle();
    check("ee queue_drained", 32'(q_ee.size()), 32'd0);
    check("fs queue_drained", 32'(q_fs.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_set_seq.md
Name: cmp_set_seq

Overview:
- Multi-cycle, parametrised set-on-condition unit for the ALU.
- Compares two WIDTH-bit operands in CHUNK-bit slices, from the most-significant slice down.
- Supports signed/unsigned LT/GT/LE/GE and EQ/NE.
- Returns a WIDTH-bit result with the flag in bit 0 and zeros elsewhere, plus raw lt/eq/gt flags.
- Signed compare is exact (sign-aware top slice), not subtraction-sign based, so it has no overflow error.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; STEPS = WIDTH/CHUNK is derived internally.
- EARLY_EXIT, 1, 1 = finish on the first differing slice; 0 = always scan all STEPS slices.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted when busy=0
- op  in  3  000 SLT, 001 SLTU, 010 SGT, 011 SGTU, 100 SEQ, 101 SNE, 110 SLE (signed), 111 SGE (signed)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- busy  out  1  high while scanning
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  {WIDTH-1 zeros, flag}
- lt  out  1  A<B under the op's signedness
- eq  out  1  A==B
- gt  out  1  A>B under the op's signedness

Behaviour:
- Reset (rst_n=0, async): state IDLE; busy, done, result, lt, eq and gt all 0; internal index and decision cleared.
- States: IDLE, SCAN, DONE.
  - IDLE: on start=1, latch a, b and op; idx=STEPS-1; decided=0; go to SCAN.
  - SCAN (busy=1): compare slice idx of A and B.
    - Top slice with signed op (SLT, SGT, SLE, SGE): invert the MSB of both slices before an unsigned compare.
    - If the slice differs and decided=0: record lt/gt and set decided=1.
    - If EARLY_EXIT=1 and the slice differs: go to DONE.
    - Otherwise, if idx==0: go to DONE.
    - Otherwise: decrement idx.
  - DONE (done=1, busy=0, one cycle):
    - result, lt, eq and gt are updated on entry to DONE. eq = !decided.
    - Flag per op: SLT/SLTU=lt, SGT/SGTU=gt, SEQ=eq, SNE=!eq, SLE=lt|eq, SGE=gt|eq.
    - Next state is SCAN if start=1 (back-to-back accept), else IDLE.
- Latency, with start accepted at edge 0 and j = position of the first differing slice from the top (0-based):
  - EARLY_EXIT=1: done high in cycle j+2.
  - Equal operands, or EARLY_EXIT=0: done high in cycle STEPS+1.
- Holding: result/lt/eq/gt hold their values until the next DONE entry. a, b and op may change freely after acceptance.
- start while busy=1: ignored; no queueing.
- Reset mid-scan: immediate abort; all outputs return to 0; a new start after reset release is accepted normally.
- STEPS=1 (CHUNK=WIDTH): the single slice is top and bottom; done high in cycle 2.
- Bits result[WIDTH-1:1] are always 0.

Test Plan:
- Signed vs unsigned (WIDTH=32, CHUNK=8, EARLY_EXIT=1):
  - SLT a=0xFFFFFFFF, b=0x00000001 -> result=0x00000001, lt=1, done in cycle 2.
  - Same operands with SLTU -> result=0, gt=1.
- Overflow case: SGT a=0x7FFFFFFF, b=0x80000000 -> result=1. SLT on the same operands -> result=0.
- Full scan / equality:
  - SEQ a=b=0x12345678 -> result=1, eq=1, done in cycle 5.
  - SLTU a=0x12345600, b=0x12345601 -> result=1, done in cycle 5.
  - SLE a=b -> 1; SNE a=b -> 0.
- Latency with EARLY_EXIT=0: SLTU a=0x00000000, b=0xFF000000 -> result=1, done in cycle 5 (not 2); lt is not overwritten by the lower equal slices.
- Handshake:
  - start pulsed during busy -> ignored, original result returned.
  - start held in the DONE cycle -> new op accepted and busy the next cycle.
  - done is exactly one cycle wide.
- Reset: drop rst_n in SCAN cycle 2 -> busy=done=result=0 asynchronously. After release, SGE a=5, b=5 -> result=1.
